// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder: one full-adder cell plus a carry flip-flop, reused
// over WIDTH clocks, LSB first. Operands enter through a valid/ready handshake
// and the result leaves through a second valid/ready handshake.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN): adds input `sub`. When sub=1
// at the accepting edge the block computes a - b - cin by capturing ~b, loading
// the carry with ~cin and reporting ~final carry as borrow-out on cout.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b/cin (and sub) valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in (borrow-in when subtracting)
//   sub        subtract select (only with SERIAL_ADDER_SUB_EN)
//   out_valid  result valid, held until accepted
//   out_ready  downstream accepts result
//   sum        WIDTH-bit result
//   cout       carry-out (borrow-out when subtracting)
//   overflow   signed overflow: carry into MSB XOR carry out of MSB
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 low sum bits already produced; the MSB is the bit
    // computed on the final edge, so it never needs a slot here.
    logic [WIDTH-2:0] sum_sh;
    logic             carry;
    logic             msb_carry;   // carry into the MSB position
    logic [CW-1:0]    cnt;

    // Operand conditioning at the accepting edge: subtraction is addition of
    // the inverted subtrahend with an inverted carry-in.
    logic [WIDTH-1:0] b_load;
    logic             cin_load;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q;
    assign b_load   = sub ? ~b   : b;
    assign cin_load = sub ? ~cin : cin;
`else
    assign b_load   = b;
    assign cin_load = cin;
`endif

    // The single full-adder cell.
    logic bit_s;
    logic carry_nxt;
    assign bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    logic cout_nxt;
`ifdef SERIAL_ADDER_SUB_EN
    assign cout_nxt = sub_q ? ~carry_nxt : carry_nxt;
`else
    assign cout_nxt = carry_nxt;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the pre-edge values of the others, as in hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            msb_carry <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= cin_load;
                        cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q <= sub;
`endif
                        state <= RUN;
                    end
                end

                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_nxt;
                    // Shift the new bit in at the top; the oldest bit drops
                    // toward the LSB.
                    sum_sh <= (WIDTH-1)'({bit_s, sum_sh} >> 1);
                    cnt    <= cnt + 1'b1;
                    if (cnt == PENULT_BIT) begin
                        msb_carry <= carry_nxt;
                    end
                    if (cnt == LAST_BIT) begin
                        sum      <= {bit_s, sum_sh};
                        cout     <= cout_nxt;
                        overflow <= msb_carry ^ carry_nxt;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH=8). Directed vectors from the
// test plan plus randomized operations, each compared with an arithmetic
// reference model. Define SERIAL_ADDER_SUB_EN for both files to exercise the
// subtract path.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_tests;
    int n_fail;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed(input logic [W-1:0] v);
        return int'(v) - (v[W-1] ? (1 << W) : 0);
    endfunction

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [W-1:0] es, output logic eco,
                                  output logic eov);
        int u;
        int r;
        if (msub) begin
            u   = int'(ma) - int'(mb) - int'(mcin);
            r   = to_signed(ma) - to_signed(mb) - int'(mcin);
            eco = (u < 0);
        end else begin
            u   = int'(ma) + int'(mb) + int'(mcin);
            r   = to_signed(ma) + to_signed(mb) + int'(mcin);
            eco = (u >= (1 << W));
        end
        es  = W'(u & ((1 << W) - 1));
        eov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    // One complete operation. hold = cycles of backpressure after out_valid,
    // during which junk operands are offered and must be ignored.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic ocin, input logic osub, input int hold);
        logic [W-1:0] es;
        logic         eco;
        logic         eov;
        int           n;
        logic         eff_sub;
`ifdef SERIAL_ADDER_SUB_EN
        eff_sub = osub;
`else
        eff_sub = 1'b0;
`endif
        model(oa, ob, ocin, eff_sub, es, eco, eov);

        n = 0;
        while (!in_ready && n < 4 * W) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'd1);

        a        = oa;
        b        = ob;
        cin      = ocin;
`ifdef SERIAL_ADDER_SUB_EN
        sub      = osub;
`endif
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble operands after acceptance; they must have no effect.
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        check("in_ready_low_in_run", 32'(in_ready), 32'd0);

        n = 0;
        while (n < 3 * W) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
        check("latency", 32'(n), 32'(W));
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(eco));
        check("overflow", 32'(overflow), 32'(eov));

        for (int i = 0; i < hold; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum_stable", 32'(sum), 32'(es));
            check("bp_cout_stable", 32'(cout), 32'(eco));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("sum_retained", 32'(sum), 32'(es));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);
        check("rel_sum", 32'(sum), 32'h00);
        check("rel_cout", 32'(cout), 32'd0);
        check("rel_overflow", 32'(overflow), 32'd0);

        // Directed vectors.
        do_op(8'h5A, 8'h33, 1'b0, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0, 0);
        do_op(8'h7F, 8'h00, 1'b1, 1'b0, 0);

        // Backpressure for 5 cycles, then a normal op.
        do_op(8'hC3, 8'h9E, 1'b1, 1'b0, 5);
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 0);

        // Reset in the middle of RUN.
        a        = 8'hAA;
        b        = 8'h55;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_sum", 32'(sum), 32'h00);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h10, 8'h01, 1'b1, 1'b1, 0);
        do_op(8'h00, 8'h01, 1'b0, 1'b1, 0);
        do_op(8'h02, 8'h03, 1'b0, 1'b0, 0);
`endif

        // Randomized operations with random backpressure.
        for (int k = 0; k < 40; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
